// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
// State encoding is binary; unused codes recover to IDLE.
package mult_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        INIT  = ST_INIT,
        ADD   = ST_ADD,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } mult_state_t;

endpackage

// File: rtl/step_counter.sv
// Iteration counter: clear, increment and terminal detect at WIDTH-1.
// The sequencer stops incrementing at terminal, so the count never wraps.
module step_counter
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Handshaked sequencer for the shift-and-add multiplier datapath.
// Control flags are registered from the next state; add_en also gates q0.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             q0,
    output logic             ld_regs,
    output logic             clr_acc,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step
);

    mult_state_t state;
    mult_state_t nxt;
    logic        add_q;
    logic        last;
    logic        cnt_clr;
    logic        cnt_inc;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (load) nxt = INIT;
            INIT:    nxt = ADD;
            ADD:     nxt = SHIFT;
            SHIFT:   nxt = last ? DONE : ADD;
            DONE:    if (load) nxt = INIT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ld_regs  <= 1'b0;
            clr_acc  <= 1'b0;
            add_q    <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt;
            ld_regs  <= (nxt == INIT);
            clr_acc  <= (nxt == INIT);
            add_q    <= (nxt == ADD);
            shift_en <= (nxt == SHIFT);
            busy     <= (nxt == INIT) || (nxt == ADD) || (nxt == SHIFT);
            done     <= (nxt == DONE);
        end
    end

    assign add_en  = add_q & q0;
    assign cnt_clr = (state == INIT);
    assign cnt_inc = (state == SHIFT) && !last;

    step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (step),
        .last  (last)
    );

endmodule
